// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: branch conditions, memory sizes, result select
// encoding and the EX/MEM pipeline entry layout.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] write_data;
    logic [RD_W-1:0] rd;
    logic            reg_write;
    logic            mem_write;
    logic            mem_read;
    logic [1:0]      result_src;
    logic [2:0]      funct3;
    logic            misalign;
  } ex_mem_entry_t;

  // Only memory accesses can be misaligned; byte accesses never are.
  function automatic logic mem_misaligned(input logic [1:0] size, input logic [1:0] addr_lo,
                                          input logic is_mem);
    logic mis;
    mis = 1'b0;
    if (is_mem) begin
      case (size)
        MEM_H:   mis = addr_lo[0];
        MEM_W:   mis = (addr_lo != 2'b00);
        default: mis = 1'b0;
      endcase
    end else begin
      mis = 1'b0;
    end
    return mis;
  endfunction

endpackage

// File: rtl/ex_mem_skid_stage_branch_cond.sv
// Combinational branch decision: maps ALU compare flags and funct3 to a taken bit.
module branch_cond
  import riscv_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_zero,
  input  logic       i_sign,
  input  logic       i_overflow,
  input  logic       i_LTU,
  output logic       o_taken
);

  // Signed less-than is sign XOR overflow of the subtraction.
  always_comb begin
    o_taken = 1'b0;
    case (i_funct3)
      BEQ:     o_taken = i_zero;
      BNE:     o_taken = ~i_zero;
      BLT:     o_taken = i_sign ^ i_overflow;
      BGE:     o_taken = ~(i_sign ^ i_overflow);
      BLTU:    o_taken = i_LTU;
      BGEU:    o_taken = ~i_LTU;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX/MEM boundary with a two-entry skid buffer and registered branch redirect.
// Optional feature macro: EX_MEM_MISALIGN_CHECK_EN (load/store misalignment flag).
module ex_mem_skid_stage
  import riscv_pkg::*;
#(
  parameter int Oprand_Width = 32,
  parameter int Rd_Width     = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid_E,
  output logic                    o_ready_E,
  input  logic [Oprand_Width-1:0] i_ALU_Res_E,
  input  logic                    i_zero_E,
  input  logic                    i_sign_E,
  input  logic                    i_overflow_E,
  input  logic                    i_LTU_E,
  input  logic                    i_Branch_E,
  input  logic [2:0]              i_funct3_E,
  input  logic [Oprand_Width-1:0] i_PCTarget_E,
  input  logic [Oprand_Width-1:0] i_WriteData_E,
  input  logic [Rd_Width-1:0]     i_Rd_E,
  input  logic                    i_RegWrite_E,
  input  logic                    i_MemWrite_E,
  input  logic                    i_MemRead_E,
  input  logic [1:0]              i_ResultSrc_E,
  input  logic                    i_flush,
  output logic                    o_valid_M,
  input  logic                    i_ready_M,
  output logic [Oprand_Width-1:0] o_ALU_Res_M,
  output logic [Oprand_Width-1:0] o_WriteData_M,
  output logic [Rd_Width-1:0]     o_Rd_M,
  output logic                    o_RegWrite_M,
  output logic                    o_MemWrite_M,
  output logic                    o_MemRead_M,
  output logic [1:0]              o_ResultSrc_M,
  output logic [2:0]              o_funct3_M,
  output logic                    o_redirect,
  output logic [Oprand_Width-1:0] o_PCTarget,
  output logic                    o_misalign_M
);

  ex_mem_entry_t             r_out, r_skid, w_new;
  logic                      r_out_v, r_skid_v, r_ready_E;
  logic                      r_redirect;
  logic [Oprand_Width-1:0]   r_PCTarget;
  logic                      w_in, w_out, w_taken, w_misalign, w_redirect;

  assign w_in       = i_valid_E & r_ready_E;
  assign w_out      = r_out_v & i_ready_M;
  assign w_redirect = w_in & i_Branch_E & w_taken & ~i_flush;

  branch_cond u_branch_cond (
    .i_funct3   (i_funct3_E),
    .i_zero     (i_zero_E),
    .i_sign     (i_sign_E),
    .i_overflow (i_overflow_E),
    .i_LTU      (i_LTU_E),
    .o_taken    (w_taken)
  );

`ifdef EX_MEM_MISALIGN_CHECK_EN
  assign w_misalign = mem_misaligned(i_funct3_E[1:0], i_ALU_Res_E[1:0],
                                     i_MemRead_E | i_MemWrite_E);
`else
  assign w_misalign = 1'b0;
`endif

  // Assemble the incoming entry; a misaligned store never reaches memory.
  always_comb begin
    w_new            = '0;
    w_new.alu_res    = i_ALU_Res_E;
    w_new.write_data = i_WriteData_E;
    w_new.rd         = i_Rd_E;
    w_new.reg_write  = i_RegWrite_E;
    w_new.mem_write  = i_MemWrite_E & ~w_misalign;
    w_new.mem_read   = i_MemRead_E;
    w_new.result_src = i_ResultSrc_E;
    w_new.funct3     = i_funct3_E;
    w_new.misalign   = w_misalign;
  end

  // Skid-buffer occupancy, registered ready and redirect pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out      <= '0;
      r_skid     <= '0;
      r_out_v    <= 1'b0;
      r_skid_v   <= 1'b0;
      r_ready_E  <= 1'b1;
      r_redirect <= 1'b0;
      r_PCTarget <= '0;
    end else begin
      if (i_flush) begin
        r_out_v   <= 1'b0;
        r_skid_v  <= 1'b0;
        r_ready_E <= 1'b1;
      end else begin
        case ({r_out_v, r_skid_v})
          2'b00: begin
            if (w_in) begin
              r_out   <= w_new;
              r_out_v <= 1'b1;
            end
          end
          2'b10: begin
            if (w_in && w_out) begin
              r_out <= w_new;
            end else if (w_in) begin
              r_skid    <= w_new;
              r_skid_v  <= 1'b1;
              r_ready_E <= 1'b0;
            end else if (w_out) begin
              r_out_v <= 1'b0;
            end
          end
          2'b11: begin
            if (w_out) begin
              r_out     <= r_skid;
              r_skid_v  <= 1'b0;
              r_ready_E <= 1'b1;
            end
          end
          default: begin
            r_out_v   <= 1'b0;
            r_skid_v  <= 1'b0;
            r_ready_E <= 1'b1;
          end
        endcase
      end
      r_redirect <= w_redirect;
      if (w_redirect) begin
        r_PCTarget <= i_PCTarget_E;
      end
    end
  end

  assign o_ready_E     = r_ready_E;
  assign o_valid_M     = r_out_v;
  assign o_ALU_Res_M   = r_out.alu_res;
  assign o_WriteData_M = r_out.write_data;
  assign o_Rd_M        = r_out.rd;
  assign o_RegWrite_M  = r_out.reg_write;
  assign o_MemWrite_M  = r_out.mem_write;
  assign o_MemRead_M   = r_out.mem_read;
  assign o_ResultSrc_M = r_out.result_src;
  assign o_funct3_M    = r_out.funct3;
  assign o_misalign_M  = r_out.misalign;
  assign o_redirect    = r_redirect;
  assign o_PCTarget    = r_PCTarget;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Self-checking bench for ex_mem_skid_stage: queue scoreboard of held entries,
// a branch-condition vector table and hand-written stall/flush/reset sequences.
module tb_ex_mem_skid_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_E, ready_E, zero_E, sign_E, ovf_E, ltu_E, branch_E;
  logic [2:0]  funct3_E;
  logic [31:0] alu_E, target_E, wd_E;
  logic [4:0]  rd_E;
  logic        regw_E, memw_E, memr_E;
  logic [1:0]  rsrc_E;
  logic        flush, valid_M, ready_M;
  logic [31:0] alu_M, wd_M, pct;
  logic [4:0]  rd_M;
  logic        regw_M, memw_M, memr_M, redirect, mis_M;
  logic [1:0]  rsrc_M;
  logic [2:0]  f3_M;

  always #5 clk = ~clk;

  ex_mem_skid_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid_E(valid_E), .o_ready_E(ready_E),
    .i_ALU_Res_E(alu_E), .i_zero_E(zero_E), .i_sign_E(sign_E), .i_overflow_E(ovf_E),
    .i_LTU_E(ltu_E), .i_Branch_E(branch_E), .i_funct3_E(funct3_E), .i_PCTarget_E(target_E),
    .i_WriteData_E(wd_E), .i_Rd_E(rd_E), .i_RegWrite_E(regw_E), .i_MemWrite_E(memw_E),
    .i_MemRead_E(memr_E), .i_ResultSrc_E(rsrc_E), .i_flush(flush), .o_valid_M(valid_M),
    .i_ready_M(ready_M), .o_ALU_Res_M(alu_M), .o_WriteData_M(wd_M), .o_Rd_M(rd_M),
    .o_RegWrite_M(regw_M), .o_MemWrite_M(memw_M), .o_MemRead_M(memr_M),
    .o_ResultSrc_M(rsrc_M), .o_funct3_M(f3_M), .o_redirect(redirect), .o_PCTarget(pct),
    .o_misalign_M(mis_M)
  );

  typedef struct {
    logic valid, branch, z, s, v, l, regw, memw, memr, ready_m, flush;
    logic [31:0] alu, wd, target;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  rsrc;
  } vec_t;

  typedef struct {
    logic [31:0] alu, wd;
    logic [4:0]  rd;
    logic        regw, memw, memr, mis;
    logic [1:0]  rsrc;
    logic [2:0]  f3;
  } exp_t;

  typedef struct {
    logic [2:0] f3;
    logic z, s, v, l, exp_taken;
  } br_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic        exp_redirect = 1'b0;
  logic [31:0] exp_target = 32'h0;
  br_t         tbl[12];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk32(name, {31'b0, act}, {31'b0, exp});
  endtask

  function automatic logic model_taken(input logic [2:0] f3, input logic z, s, v, l);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return s != v;
      3'b101:  return s == v;
      3'b110:  return l;
      3'b111:  return !l;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t make_exp();
    exp_t e;
    e.alu = alu_E; e.wd = wd_E; e.rd = rd_E; e.regw = regw_E; e.memr = memr_E;
    e.rsrc = rsrc_E; e.f3 = funct3_E; e.mis = 1'b0;
`ifdef EX_MEM_MISALIGN_CHECK_EN
    if (memr_E || memw_E) begin
      if (funct3_E[1:0] == 2'b01) e.mis = alu_E[0];
      else if (funct3_E[1:0] == 2'b10) e.mis = (alu_E[1:0] != 2'b00);
    end
`endif
    e.memw = memw_E && !e.mis;
    return e;
  endfunction

  // Compare current outputs against the model, then advance the model across one edge.
  task automatic cycle();
    logic do_in, do_out, nxt_red;
    chk1("valid_M", valid_M, q.size() != 0);
    chk1("ready_E", ready_E, q.size() < 2);
    chk1("redirect", redirect, exp_redirect);
    if (exp_redirect) chk32("pctarget", pct, exp_target);
    if (q.size() != 0) begin
      chk32("alu_M", alu_M, q[0].alu);
      chk32("wd_M", wd_M, q[0].wd);
      chk32("rd_M", {27'b0, rd_M}, {27'b0, q[0].rd});
      chk1("regw_M", regw_M, q[0].regw);
      chk1("memw_M", memw_M, q[0].memw);
      chk1("memr_M", memr_M, q[0].memr);
      chk32("rsrc_M", {30'b0, rsrc_M}, {30'b0, q[0].rsrc});
      chk32("f3_M", {29'b0, f3_M}, {29'b0, q[0].f3});
      chk1("misalign_M", mis_M, q[0].mis);
    end
    do_out  = (q.size() != 0) && ready_M;
    do_in   = valid_E && (q.size() < 2);
    nxt_red = do_in && branch_E && model_taken(funct3_E, zero_E, sign_E, ovf_E, ltu_E) && !flush;
    if (nxt_red) exp_target = target_E;
    if (flush) q.delete();
    else begin
      if (do_out) void'(q.pop_front());
      if (do_in) q.push_back(make_exp());
    end
    exp_redirect = nxt_red;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    valid_E = v.valid; alu_E = v.alu; wd_E = v.wd; rd_E = v.rd; regw_E = v.regw;
    memw_E = v.memw; memr_E = v.memr; rsrc_E = v.rsrc; funct3_E = v.f3; branch_E = v.branch;
    zero_E = v.z; sign_E = v.s; ovf_E = v.v; ltu_E = v.l; target_E = v.target;
    ready_M = v.ready_m; flush = v.flush;
    cycle();
  endtask

  function automatic vec_t idle(input logic rm);
    vec_t v;
    v.valid = 1'b0; v.branch = 1'b0; v.z = 1'b0; v.s = 1'b0; v.v = 1'b0; v.l = 1'b0;
    v.regw = 1'b0; v.memw = 1'b0; v.memr = 1'b0; v.ready_m = rm; v.flush = 1'b0;
    v.alu = 32'h0; v.wd = 32'h0; v.target = 32'h0; v.rd = 5'd0; v.f3 = 3'd0; v.rsrc = 2'd0;
    return v;
  endfunction

  function automatic vec_t alu_v(input logic [31:0] a, input logic rm);
    vec_t v;
    v = idle(rm);
    v.valid = 1'b1; v.alu = a; v.wd = ~a; v.rd = a[4:0]; v.regw = 1'b1; v.rsrc = 2'b00;
    return v;
  endfunction

  function automatic vec_t br_v(input br_t b, input logic [31:0] tgt, input logic rm);
    vec_t v;
    v = idle(rm);
    v.valid = 1'b1; v.branch = 1'b1; v.f3 = b.f3; v.z = b.z; v.s = b.s; v.v = b.v;
    v.l = b.l; v.target = tgt;
    return v;
  endfunction

  function automatic vec_t mem_v(input logic [31:0] a, input logic [2:0] f3,
                                 input logic wr, input logic rm);
    vec_t v;
    v = idle(rm);
    v.valid = 1'b1; v.alu = a; v.wd = 32'hDEAD_0000 | a; v.f3 = f3; v.rd = 5'd9;
    v.memw = wr; v.memr = !wr; v.regw = !wr; v.rsrc = wr ? 2'b00 : 2'b01;
    return v;
  endfunction

  initial begin
    vec_t v;
    logic [31:0] rnd;
    tbl = '{
      '{3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
      '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
      '{3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
      '{3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
      '{3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
      '{3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
      '{3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
      '{3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
      '{3'b010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0},
      '{3'b011, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}
    };

    rst_n = 1'b0;
    v = idle(1'b1);
    valid_E = 1'b0; alu_E = 32'h0; wd_E = 32'h0; rd_E = 5'd0; regw_E = 1'b0; memw_E = 1'b0;
    memr_E = 1'b0; rsrc_E = 2'd0; funct3_E = 3'd0; branch_E = 1'b0; zero_E = 1'b0;
    sign_E = 1'b0; ovf_E = 1'b0; ltu_E = 1'b0; target_E = 32'h0; ready_M = 1'b1; flush = 1'b0;
    @(posedge clk);
    #1;
    chk1("rst_valid_M", valid_M, 1'b0);
    chk1("rst_ready_E", ready_E, 1'b1);
    chk1("rst_redirect", redirect, 1'b0);
    chk1("rst_misalign", mis_M, 1'b0);
    chk32("rst_alu_M", alu_M, 32'h0);
    chk32("rst_pctarget", pct, 32'h0);
    chk1("rst_memw_M", memw_M, 1'b0);
    rst_n = 1'b1;
    apply(idle(1'b1));

    // Single entry through an empty stage
    apply(alu_v(32'h0000_1234, 1'b1));
    chk32("single_alu", alu_M, 32'h0000_1234);
    apply(idle(1'b1));
    apply(idle(1'b1));

    // Stall with back-to-back entries, then drain
    apply(alu_v(32'h1, 1'b0));
    apply(alu_v(32'h2, 1'b0));
    chk1("stall_ready_low", ready_E, 1'b0);
    apply(alu_v(32'h3, 1'b0));
    apply(idle(1'b0));
    apply(idle(1'b1));
    apply(idle(1'b1));
    apply(idle(1'b1));
    chk1("drain_ready_high", ready_E, 1'b1);

    // Branch condition table
    for (int i = 0; i < 12; i++) begin
      apply(br_v(tbl[i], 32'h80 + 32'(i) * 32'd4, 1'b1));
      chk1("redirect_tbl", redirect, tbl[i].exp_taken);
      apply(idle(1'b1));
    end

    // Flush while FULL with a new taken branch presented
    apply(alu_v(32'hA, 1'b0));
    apply(alu_v(32'hB, 1'b0));
    v = br_v(tbl[0], 32'h200, 1'b0);
    v.flush = 1'b1;
    apply(v);
    chk1("flush_full_valid", valid_M, 1'b0);
    apply(idle(1'b1));

    // Flush in ONE with a taken branch accepted: dropped, no redirect
    apply(alu_v(32'hC, 1'b0));
    v = br_v(tbl[0], 32'h300, 1'b0);
    v.flush = 1'b1;
    apply(v);
    chk1("flush_no_redirect", redirect, 1'b0);
    apply(idle(1'b1));

    // Flush together with a transfer out ends EMPTY; flush leaves a live redirect pulse
    apply(br_v(tbl[3], 32'h400, 1'b1));
    v = idle(1'b1);
    v.flush = 1'b1;
    apply(v);
    apply(idle(1'b1));

    // Load/store alignment
    apply(mem_v(32'h1002, 3'b010, 1'b1, 1'b1));
    apply(mem_v(32'h1002, 3'b001, 1'b0, 1'b1));
    apply(mem_v(32'h1003, 3'b001, 1'b1, 1'b1));
    apply(mem_v(32'h1001, 3'b000, 1'b1, 1'b1));
    apply(mem_v(32'h1004, 3'b010, 1'b1, 1'b1));
    apply(idle(1'b1));

    // Random traffic against the scoreboard
    for (int i = 0; i < 200; i++) begin
      rnd = $urandom;
      v = idle(rnd[0] | rnd[1]);
      v.valid = rnd[2] | rnd[3];
      v.flush = (rnd[7:4] == 4'd0);
      v.branch = rnd[8];
      v.f3 = rnd[11:9];
      v.z = rnd[12]; v.s = rnd[13]; v.v = rnd[14]; v.l = rnd[15];
      v.memw = !rnd[8] && rnd[16];
      v.memr = !rnd[8] && !rnd[16] && rnd[17];
      v.regw = rnd[18];
      v.rsrc = rnd[20:19];
      v.rd = rnd[25:21];
      v.alu = $urandom;
      v.wd = $urandom;
      v.target = $urandom;
      apply(v);
    end
    apply(idle(1'b1));
    apply(idle(1'b1));

    // Asynchronous reset while FULL, between edges
    apply(alu_v(32'h11, 1'b0));
    apply(alu_v(32'h22, 1'b0));
    valid_E = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk1("async_rst_valid", valid_M, 1'b0);
    chk1("async_rst_ready", ready_E, 1'b1);
    chk1("async_rst_redirect", redirect, 1'b0);
    q.delete();
    exp_redirect = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(idle(1'b1));
    apply(alu_v(32'h33, 1'b1));
    apply(idle(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
